// File: rtl/sram2_parity_master_if.sv
// Request/response bus between the core load/store path and the SRAM2 initiator.
// master: the core side that issues requests; slave: the SRAM2 initiator.
interface sram2_parity_master_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_address;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_status;

  modport master (
    output req_valid, req_write, req_address, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_status
  );

  modport slave (
    input  req_valid, req_write, req_address, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_status
  );
endinterface

// File: rtl/sram2_parity_master.sv
// SRAM2 initiator: single-word read/write requests, alignment and window checks,
// per-byte even parity on writes, read capture with parity error reporting.
// Optional feature macro: SRAM2_READ_RETRY_EN re-reads up to MAX_RETRY times
// after a parity error before reporting it.
module sram2_parity_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [31:0] SIZE_BYTES = 32'h0000_1000,
  parameter int          MAX_RETRY  = 2,
  parameter int          ERR_CNT_W  = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  sram2_parity_master_if.slave bus,
  output logic                 sram_write_enable,
  output logic [31:0]          sram_address,
  output logic [35:0]          sram_data_in,
  input  logic [31:0]          sram_data_out,
  input  logic                 sram_parity_error_flag,
  output logic [ERR_CNT_W-1:0] error_count
);

  localparam logic [1:0] ST_OK     = 2'b00;
  localparam logic [1:0] ST_PARITY = 2'b01;
  localparam logic [1:0] ST_RANGE  = 2'b10;
  localparam logic [1:0] ST_ALIGN  = 2'b11;

  // End of window kept 33 bits wide so a window touching 0xFFFF_FFFF does not wrap.
  localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + {1'b0, SIZE_BYTES};

  if (MAX_RETRY < 0) begin : g_bad_max_retry
    $fatal(1, "MAX_RETRY must be non-negative");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t                 state_q, state_d;
  logic                   we_q, we_d;
  logic [31:0]            addr_q, addr_d;
  logic [35:0]            din_q, din_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [1:0]             status_q, status_d;
  logic [ERR_CNT_W-1:0]   err_q, err_d;
  logic                   req_ready;
  logic                   misaligned;
  logic                   in_range;

`ifdef SRAM2_READ_RETRY_EN
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RETRY_W-1:0]     retry_q, retry_d;
`endif

  // Even parity per byte: each parity bit makes its byte plus parity have an even count of ones.
  function automatic logic [3:0] byte_parity(input logic [31:0] d);
    logic [3:0] p;
    for (int i = 0; i < 4; i++) begin
      p[i] = ^d[8*i +: 8];
    end
    return p;
  endfunction

  assign req_ready      = (state_q == S_IDLE) && !rsp_valid_q;
  assign misaligned     = (bus.req_address[1:0] != 2'b00);
  assign in_range       = (bus.req_address >= BASE_ADDR) && ({1'b0, bus.req_address} < WIN_END);

  assign bus.req_ready      = req_ready;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rdata_q;
  assign bus.rsp_status     = status_q;
  assign sram_write_enable  = we_q;
  assign sram_address       = addr_q;
  assign sram_data_in       = din_q;
  assign error_count        = err_q;

  // Next-state and next-output computation for the access sequencer.
  always_comb begin
    state_d     = state_q;
    we_d        = 1'b0;
    addr_d      = addr_q;
    din_d       = din_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    status_d    = status_q;
    err_d       = err_q;
`ifdef SRAM2_READ_RETRY_EN
    retry_d     = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef SRAM2_READ_RETRY_EN
        retry_d = '0;
`endif
        if (bus.req_valid && req_ready) begin
          if (misaligned) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            status_d    = ST_ALIGN;
            rdata_d     = '0;
          end else if (!in_range) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            status_d    = ST_RANGE;
            rdata_d     = '0;
          end else if (bus.req_write) begin
            state_d = S_WRITE;
            we_d    = 1'b1;
            addr_d  = bus.req_address;
            din_d   = {byte_parity(bus.req_wdata), bus.req_wdata};
          end else begin
            state_d = S_READ;
            addr_d  = bus.req_address;
          end
        end
      end
      S_WRITE: begin
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        status_d    = ST_OK;
        rdata_d     = '0;
      end
      S_READ: begin
        state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
`ifdef SRAM2_READ_RETRY_EN
        if (sram_parity_error_flag && (retry_q < RETRY_W'(MAX_RETRY))) begin
          state_d = S_READ;
          retry_d = retry_q + 1'b1;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rdata_d     = sram_data_out;
          status_d    = sram_parity_error_flag ? ST_PARITY : ST_OK;
        end
`else
        state_d     = S_RESP;
        rsp_valid_d = 1'b1;
        rdata_d     = sram_data_out;
        status_d    = sram_parity_error_flag ? ST_PARITY : ST_OK;
`endif
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Count failed responses as they are issued; stick at all-ones.
    if (rsp_valid_d && (status_d != ST_OK) && (err_q != {ERR_CNT_W{1'b1}})) begin
      err_d = err_q + 1'b1;
    end
  end

  // State and registered outputs; reset aborts any access and drops write enable at once.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      din_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      status_q    <= ST_OK;
      err_q       <= '0;
`ifdef SRAM2_READ_RETRY_EN
      retry_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      din_q       <= din_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      status_q    <= status_d;
      err_q       <= err_d;
`ifdef SRAM2_READ_RETRY_EN
      retry_q     <= retry_d;
`endif
    end
  end

endmodule
